// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - RV32I writeback stage: result mux, 32x32 register file with bypass, perf counters
//
// Purpose:
//   Consumes the MEM/WB pipeline fields, selects the writeback result and
//   commits it to the integer register file. The two decode read ports see a
//   same-cycle write through a bypass. 64-bit cycle and instret counters.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   RegWriteW     W-stage register write enable
//   ResultSrcW    00 ALUResultW, 01 ReadDataW, 10 PCPlus4W, 11 ImmExtW
//   ALUResultW, ReadDataW, PCPlus4W, ImmExtW   W-stage result candidates
//   RdW           destination register index
//   ValidW        W stage holds a real instruction
//   A1D, A2D      decode read addresses
//   RD1D, RD2D    decode read data (combinational, bypassed)
//   ResultW       selected writeback value
//   CycleCnt      cycles since reset
//   InstretCnt    retired instructions since reset

module writeback_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNTW  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic [XLEN-1:0] ImmExtW,
    input  logic [4:0]      RdW,
    input  logic            ValidW,
    input  logic [4:0]      A1D,
    input  logic [4:0]      A2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ResultW,
    output logic [CNTW-1:0] CycleCnt,
    output logic [CNTW-1:0] InstretCnt
);

    logic [XLEN-1:0] regs [NREGS];
    logic [CNTW-1:0] cycle_q;
    logic [CNTW-1:0] instret_q;
    logic            wr_en;

    // A bubble (ValidW=0) or a write to x0 never commits and never bypasses.
    assign wr_en = RegWriteW & ValidW & (RdW != 5'd0);

    always_comb begin
        ResultW = ALUResultW;
        case (ResultSrcW)
            2'b00:   ResultW = ALUResultW;
            2'b01:   ResultW = ReadDataW;
            2'b10:   ResultW = PCPlus4W;
            default: ResultW = ImmExtW;
        endcase
    end

    // x0 is never written, so its storage stays at its reset value of 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[RdW] <= ResultW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            if (ValidW) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    assign CycleCnt   = cycle_q;
    assign InstretCnt = instret_q;

    // Bypass replaces the classic negedge write: a reader of the register
    // being committed this cycle sees the new value. Reads are held at 0
    // during reset so the bypass cannot leak ResultW while rst is high.
    always_comb begin
        RD1D = '0;
        if (!rst && A1D != 5'd0) begin
            RD1D = (wr_en && RdW == A1D) ? ResultW : regs[A1D];
        end
    end

    always_comb begin
        RD2D = '0;
        if (!rst && A2D != 5'd0) begin
            RD2D = (wr_en && RdW == A2D) ? ResultW : regs[A2D];
        end
    end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
Writeback-side consumer of the MEM/WB pipeline register in the pipelined RV32I core. It selects the writeback result from the W-stage fields and commits it to a 32x32 integer register file. It serves the two decode-stage read ports with same-cycle write-through bypass. It also maintains 64-bit cycle and retired-instruction counters for performance readout.

Parameters:
XLEN, 32, data width of registers, results and read ports
NREGS, 32, number of architectural registers (x0..x31); index width is 5
CNTW, 64, width of the cycle and instret counters

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
RegWriteW  input  1  W-stage register write enable
ResultSrcW  input  2  result select: 00 ALUResultW, 01 ReadDataW, 10 PCPlus4W, 11 ImmExtW
ALUResultW  input  XLEN  ALU result from W stage
ReadDataW  input  XLEN  data-memory load data from W stage
PCPlus4W  input  XLEN  link address from W stage
ImmExtW  input  XLEN  extended immediate (LUI path)
RdW  input  5  destination register index
ValidW  input  1  W stage holds a real instruction (0 = bubble/flushed)
A1D  input  5  decode read address 1
A2D  input  5  decode read address 2
RD1D  output  XLEN  read data 1 (combinational)
RD2D  output  XLEN  read data 2 (combinational)
ResultW  output  XLEN  selected writeback value, to the forwarding muxes
CycleCnt  output  CNTW  cycles since reset
InstretCnt  output  CNTW  retired instructions since reset

Behaviour:
- Reset (async, rst=1): all 32 registers cleared to 0; CycleCnt=0; InstretCnt=0. RD1D/RD2D therefore read 0 while rst=1 for every address. ResultW stays combinational from its inputs and is not forced by reset.
- Result mux (combinational): ResultW is driven per ResultSrcW with no latency.
- Commit: on rising clk, if RegWriteW=1 and ValidW=1 and RdW!=0, then reg[RdW] <= ResultW.
  - Otherwise the register file is unchanged.
  - RegWriteW=1 with ValidW=0 is a bubble and writes nothing.
- x0: always reads 0. Writes to RdW=0 are discarded, including the bypass path.
- Read ports: RD1D = (A1D==0) ? 0 : bypass ? ResultW : reg[A1D]. RD2D is identical with A2D.
  - bypass = RegWriteW & ValidW & (RdW!=0) & (RdW==A1D or A2D respectively).
  - This replaces a negedge write: a same-cycle write to a register being read returns the new value.
- Both read ports may hit the same address, and both may be bypassed simultaneously.
- CycleCnt: increments by 1 every rising clk while rst=0. Wraps 2^CNTW-1 -> 0 with no flag.
- InstretCnt: increments by 1 on rising clk when ValidW=1, independent of RegWriteW, since stores and branches retire too. Same wrap rule as CycleCnt.
- Reset asserted mid-operation: all state clears immediately without waiting for clk. The first rising edge after rst deasserts is counted as cycle 1.
- No stall input: the MEM/WB register upstream holds no hazard state. A held W stage must present ValidW=0 for repeated cycles, or the instruction is counted more than once.

Test Plan:
- Reset then read: rst=1 pulse, A1D=5, A2D=31 -> RD1D=0, RD2D=0, CycleCnt=0, InstretCnt=0.
- Mux and commit: ResultSrcW=01, ReadDataW=0xDEADBEEF, RdW=7, RegWriteW=1, ValidW=1, one clk. Then A1D=7 -> RD1D=0xDEADBEEF. Repeat with ResultSrcW=10, PCPlus4W=0x104 -> ResultW=0x104.
- Bypass: in the same cycle as a write of 0x12345678 to x9, set A1D=A2D=9 -> both RD1D and RD2D=0x12345678 before the edge. After the edge the stored value is the same.
- x0 and bubble: RdW=0, ALUResultW=0xFFFFFFFF, write enabled -> RD1D for A1D=0 is 0. Then RdW=3, RegWriteW=1, ValidW=0 -> x3 unchanged and InstretCnt not incremented.
- Counters: 10 cycles with ValidW pattern 1,0,1,1,0,0,1,1,1,0 -> CycleCnt=10, InstretCnt=6. Force CycleCnt to 2^64-1 -> next edge reads 0.
- Async reset mid-run: after writing x4=0xA5A5A5A5, assert rst between clock edges -> x4, CycleCnt and InstretCnt read 0 immediately. Deassert, one clk -> CycleCnt=1.
